nibbler_clock_ctrl: RTL
=======================

# nibbler_clock_ctrl

Parametrised phase-clock controller for the Nibbler CPU, replacing the fixed free-running clock toggle used in simulation. It emits one-cycle phase-advance enables at a programmable divide rate and alternates fetch/execute phases. It supports halt, free-run, single-instruction step and counted-burst modes, and keeps an instruction counter. It sits between the top-level clock and the CPU core, which advances only on `phase_en`.

## Interface
- DIV_W, 8, width of divisor input
- CNT_W, 16, width of burst length and instruction counter
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
- div  in  DIV_W  divide ratio; 0 treated as 1 (div_eff)
- step  in  1  level input; rising edge requests one instruction in STEP
- burst_len  in  CNT_W  instructions to run on BURST entry
- cnt_clr  in  1  synchronous clear of cyc_count
- phase_en  out  1  one-cycle pulse: CPU advances this cycle
- phase  out  1  current phase, 0 fetch, 1 execute
- cyc_count  out  CNT_W  completed instructions, wraps modulo 2^CNT_W
- busy  out  1  burst in progress
- halted  out  1  combinational: no tick can currently occur

## Operation
- Reset (rst_n=0 at edge): pre=0, phase=0, phase_en=0, cyc_count=0, busy=0, armed=0, step_q=0, mode_q=00, remaining=0.
- Internal mode_q registers mode each cycle; mode_change = (mode != mode_q).
  - On mode_change: pre<=0, no tick, armed<=0, busy<=0 unless entering BURST.
- active = RUN | (STEP & armed) | (BURST & busy). halted = ~active.
- Prescaler: when active and no mode_change, pre increments.
  - tick = active & ~mode_change & (pre >= div_eff-1). Using >= makes a div decrease mid-count fire on the next cycle instead of wrapping.
  - On tick: pre<=0, phase<=~phase, phase_en<=1. phase_en<=0 otherwise.
  - When not active, pre holds 0.
- Instruction completion = tick with phase==1 (new phase 0): cyc_count+1 (wrap). cnt_clr same cycle wins, giving 0.
- STEP: step_q<=step; edge = step & ~step_q.
  - edge while mode==STEP, ~armed, ~mode_change sets armed<=1.
  - Edges while armed or in other modes are ignored.
  - armed clears on the completing tick: two ticks from phase 0, one tick from phase 1.
- BURST entry (mode_change to 11): remaining<=burst_len, busy<=(burst_len!=0).
  - Each completion decrements remaining.
  - The completion making remaining 0 clears busy on the same edge.
  - Stays idle in BURST until mode leaves and re-enters. burst_len=0 produces no ticks.
- HALT or any mode change preserves phase; resume continues mid-instruction.

## Timing
- Outputs phase_en, phase, cyc_count, busy are registered; halted is combinational from mode/state.
- RUN from HALT, mode applied in cycle 0: first phase_en in cycle div_eff+1, then every div_eff cycles.
  - div=1 gives phase_en high continuously from cycle 2.
- Out of reset with mode=RUN held: mode_q=00 makes cycle 0 after reset a mode change; first pulse in cycle div_eff+1.
- STEP: step edge seen in cycle k sets armed at k+1; first phase_en in cycle k+1+div_eff.
- Reset asserted mid-burst or mid-step: all state returns to reset values on that edge; phase_en low the next cycle.

## Test plan
- Reset with mode=RUN, div=3 -> phase_en pulses in cycles 4,7,10,13; phase 1,0,1,0; cyc_count 1 after cycle 7's pulse, 2 after cycle 13's.
- RUN div=0 vs div=1 -> identical traces; phase_en high every cycle from cycle 2; cyc_count +1 every 2 cycles.
- STEP div=2, phase=0, step rising edge -> exactly 2 phase_en pulses, cyc_count +1, halted returns 1.
  - Second step edge while armed -> ignored, still only 2 pulses.
- BURST burst_len=3 div=2 -> 6 pulses, cyc_count +3, busy falls on the same edge as the 6th pulse.
  - burst_len=0 -> no pulses, busy never 1.
- RUN div=2 switched to HALT right after a fetch pulse (phase=1) -> no pulses, phase holds 1.
  - Then STEP edge -> exactly 1 pulse, phase=0, cyc_count +1.
- cnt_clr asserted on a completing tick with cyc_count=0xFFFF -> cyc_count=0.
  - Without clr, 0xFFFF + completion -> 0x0000 (wrap).

Source files
------------

// File: rtl/nibbler_clock_ctrl.sv
// ---------------------------------------------------------------------------
// nibbler_clock_ctrl
//
// Phase-clock controller for the Nibbler CPU. The core advances only in
// cycles where phase_en is high. This block divides the system clock by a
// programmable ratio and alternates fetch (phase 0) and execute (phase 1).
// A fetch/execute pair is one instruction. Four run modes are supported:
// halt, free-run, single-instruction step and counted burst. Completed
// instructions are counted in cyc_count.
//
// Parameters
//   DIV_W      width of the divide-ratio input
//   CNT_W      width of the burst length and the instruction counter
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   rst_n      synchronous, active-low reset
//   mode       00 HALT, 01 RUN, 10 STEP, 11 BURST
//   div        divide ratio; 0 behaves as 1
//   step       level input; a rising edge requests one instruction in STEP
//   burst_len  number of instructions to run when BURST is entered
//   cnt_clr    synchronous clear of cyc_count (wins over an increment)
//   phase_en   one-cycle pulse: the CPU advances this cycle
//   phase      current phase, 0 fetch, 1 execute
//   cyc_count  completed instructions, wraps modulo 2^CNT_W
//   busy       a burst is in progress
//   halted     combinational: no tick can occur in the current cycle
// ---------------------------------------------------------------------------
module nibbler_clock_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             step,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             cnt_clr,
  output logic             phase_en,
  output logic             phase,
  output logic [CNT_W-1:0] cyc_count,
  output logic             busy,
  output logic             halted
);

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  // Registered state
  logic [1:0]       mode_q;     // mode seen last cycle, for change detection
  logic [DIV_W-1:0] pre;        // prescaler count within the current phase
  logic             armed;      // a step request is being executed
  logic             step_q;     // step delayed one cycle, for edge detection
  logic [CNT_W-1:0] remaining;  // instructions left in the current burst

  // Combinational control
  logic             mode_change;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_m1;
  logic             active;
  logic             tick;
  logic             complete;
  logic             step_edge;
  logic             enter_burst;

  always_comb begin
    mode_change = (mode != mode_q);
    div_eff     = (div == '0) ? DIV_W'(1) : div;
    div_m1      = div_eff - DIV_W'(1);

    active = (mode == MODE_RUN)
           | ((mode == MODE_STEP)  & armed)
           | ((mode == MODE_BURST) & busy);

    // The >= compare means a divisor lowered below the current count fires
    // on the next cycle rather than wrapping the prescaler all the way round.
    tick = active & ~mode_change & (pre >= div_m1);

    // An instruction finishes when execute (phase 1) hands back to fetch.
    complete = tick & phase;

    step_edge   = step & ~step_q;
    enter_burst = mode_change & (mode == MODE_BURST);

    halted = ~active;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= MODE_HALT;
      pre       <= '0;
      phase     <= 1'b0;
      phase_en  <= 1'b0;
      cyc_count <= '0;
      busy      <= 1'b0;
      armed     <= 1'b0;
      step_q    <= 1'b0;
      remaining <= '0;
    end else begin
      mode_q   <= mode;
      step_q   <= step;
      phase_en <= tick;

      // Prescaler restarts on a tick, on a mode change and whenever idle.
      // It never exceeds div_m1 while counting, so it cannot overflow.
      if (active && !mode_change && !tick) begin
        pre <= pre + DIV_W'(1);
      end else begin
        pre <= '0;
      end

      // Phase is only touched by ticks, so halting or switching modes keeps
      // the CPU mid-instruction and resuming picks up where it left off.
      if (tick) begin
        phase <= ~phase;
      end

      if (cnt_clr) begin
        cyc_count <= '0;
      end else if (complete) begin
        cyc_count <= cyc_count + CNT_W'(1);
      end

      // Step request: armed only by a fresh edge in a settled STEP mode,
      // and released by the tick that finishes the instruction, so a
      // request made mid-instruction runs only the remaining phase.
      if (mode_change) begin
        armed <= 1'b0;
      end else if (complete) begin
        armed <= 1'b0;
      end else if (step_edge && (mode == MODE_STEP) && !armed) begin
        armed <= 1'b1;
      end

      // Burst bookkeeping. The length is latched only on entry; once the
      // burst drains the block idles until BURST is left and re-entered.
      if (mode_change) begin
        busy <= enter_burst && (burst_len != '0);
        if (enter_burst) begin
          remaining <= burst_len;
        end
      end else if (complete && (mode == MODE_BURST) && busy) begin
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
